// File: rtl/clk_div_prog_if.sv
// Control/status bundle for clk_div_prog: per-channel enables, global sync,
// divisor write port and the divided outputs.
interface clk_div_prog_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic              wr_err;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  wr_err, pend, clk_out, tick
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output wr_err, pend, clk_out, tick
  );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: per-channel runtime divisor,
// square-wave output and one-cycle tick, with glitch-free divisor updates.
module clk_div_prog #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 40
) (
  input  logic           clk_i,
  input  logic           rst_i,
  clk_div_prog_if.slave  bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // High-phase length ceil(n/2), computed without widening n.
  function automatic logic [DIV_W-1:0] hi_of(input logic [DIV_W-1:0] n);
    return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
  endfunction

  logic              wr_ok;
  logic              wr_err_q;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] tick_v;

  assign wr_ok = bus.wr_en
               && (32'(bus.wr_ch) < NUM_CH)
               && (bus.wr_div >= DIV_W'(2));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_q, cur_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             run_q;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             restart;
    logic             apply;
    logic             wr_hit;

    assign wr_hit = wr_ok && (bus.wr_ch == CH_W'(g));

    // Any period boundary (disable, first enabled cycle, sync, natural wrap)
    // is where a pending divisor may be swapped in.
    assign restart = !bus.en[g] || !run_q || bus.sync
                   || (cnt_q >= cur_q - DIV_W'(1));
    assign apply   = restart && pend_q;

    always_comb begin
      cnt_d     = restart ? '0 : cnt_q + DIV_W'(1);
      cur_d     = apply ? shadow_q : cur_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      // A write on the apply edge re-arms pend with the new shadow value.
      if (wr_hit) begin
        shadow_d = bus.wr_div;
        pend_d   = 1'b1;
      end else if (apply) begin
        pend_d   = 1'b0;
      end
      if (bus.en[g]) begin
        clk_out_d = (cnt_d < hi_of(cur_d));
        tick_d    = (cnt_d == '0);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q     <= '0;
        cur_q     <= DIV_W'(DEFAULT_DIV);
        shadow_q  <= DIV_W'(DEFAULT_DIV);
        pend_q    <= 1'b0;
        run_q     <= 1'b0;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        cur_q     <= cur_d;
        shadow_q  <= shadow_d;
        pend_q    <= pend_d;
        run_q     <= bus.en[g];
        clk_out_q <= clk_out_d;
        tick_q    <= tick_d;
      end
    end

    assign pend_v[g]    = pend_q;
    assign clk_out_v[g] = clk_out_q;
    assign tick_v[g]    = tick_q;
  end

  assign bus.wr_err  = wr_err_q;
  assign bus.pend    = pend_v;
  assign bus.clk_out = clk_out_v;
  assign bus.tick    = tick_v;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed scoreboard bench for clk_div_prog (4-channel main instance plus a
// 3-channel instance for out-of-range channel writes).
module tb_clk_div_prog;
  logic clk;
  logic rst;

  clk_div_prog_if #(.NUM_CH(4), .DIV_W(16)) bus ();
  clk_div_prog_if #(.NUM_CH(3), .DIV_W(16)) bus2 ();

  clk_div_prog #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(40)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  clk_div_prog #(.NUM_CH(3), .DIV_W(16), .DEFAULT_DIV(40)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  typedef struct {
    string      tag;
    logic [3:0] co;
    logic [3:0] tk;
    logic [3:0] pd;
    logic       we;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // p < 0 marks a disabled channel; otherwise p is cycles since its period origin.
  task automatic push_w(input string tag,
                        input int p0, input int n0,
                        input int p1, input int n1,
                        input int p2, input int n2,
                        input logic [3:0] pd, input logic we);
    exp_t e;
    e.tag = tag;
    e.co  = '0;
    e.tk  = '0;
    e.pd  = pd;
    e.we  = we;
    if (p0 >= 0) begin e.co[0] = (p0 % n0) < (n0 + 1) / 2; e.tk[0] = (p0 % n0) == 0; end
    if (p1 >= 0) begin e.co[1] = (p1 % n1) < (n1 + 1) / 2; e.tk[1] = (p1 % n1) == 0; end
    if (p2 >= 0) begin e.co[2] = (p2 % n2) < (n2 + 1) / 2; e.tk[2] = (p2 % n2) == 0; end
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".clk_out"}, 32'(bus.clk_out), 32'(e.co));
    check({e.tag, ".tick"},    32'(bus.tick),    32'(e.tk));
    check({e.tag, ".pend"},    32'(bus.pend),    32'(e.pd));
    check({e.tag, ".wr_err"},  32'(bus.wr_err),  32'(e.we));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      pop_cmp();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = '0;
    bus.sync    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_div  = '0;
    bus2.en     = '0;
    bus2.sync   = 1'b0;
    bus2.wr_en  = 1'b0;
    bus2.wr_ch  = '0;
    bus2.wr_div = '0;

    // Reset state
    push_w("reset", -1, 0, -1, 0, -1, 0, 4'b0000, 1'b0);
    run(1);
    rst    = 1'b0;
    bus.en = 4'b0001;

    // 1: default N=40 on ch0 only
    for (int k = 0; k < 80; k++) push_w("t1_default", k, 40, -1, 0, -1, 0, 4'b0000, 1'b0);
    run(80);

    // 2: ch1 joins in phase at N=40, then rewritten to N=5 mid-period
    bus.en = 4'b0011;
    for (int j = 0; j < 10; j++) push_w("t2_run", j, 40, j, 40, -1, 0, 4'b0000, 1'b0);
    run(10);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd1;
    bus.wr_div = 16'd5;
    push_w("t2_wr", 10, 40, 10, 40, -1, 0, 4'b0010, 1'b0);
    run(1);
    bus.wr_en = 1'b0;
    for (int j = 11; j < 40; j++) push_w("t2_pend", j, 40, j, 40, -1, 0, 4'b0010, 1'b0);
    run(29);
    for (int j = 40; j < 60; j++) push_w("t2_new", j, 40, j - 40, 5, -1, 0, 4'b0000, 1'b0);
    run(20);

    // 3: invalid writes (divisor 1, divisor 0, channel out of range on dut2)
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'd0;
    bus.wr_div  = 16'd1;
    bus2.wr_en  = 1'b1;
    bus2.wr_ch  = 2'd3;
    bus2.wr_div = 16'd10;
    push_w("t3_div1", 60, 40, 20, 5, -1, 0, 4'b0000, 1'b1);
    run(1);
    check("t3_ch3.wr_err", 32'(bus2.wr_err), 32'd1);
    check("t3_ch3.pend",   32'(bus2.pend),   32'd0);
    bus.wr_en  = 1'b0;
    bus2.wr_ch = 2'd2;
    push_w("t3_gap", 61, 40, 21, 5, -1, 0, 4'b0000, 1'b0);
    run(1);
    check("t3_ch2ok.wr_err", 32'(bus2.wr_err), 32'd0);
    check("t3_ch2ok.pend",   32'(bus2.pend),   32'b100);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd2;
    bus.wr_div = 16'd0;
    bus2.wr_en = 1'b0;
    push_w("t3_div0", 62, 40, 22, 5, -1, 0, 4'b0000, 1'b1);
    run(1);
    check("t3_dis_apply.pend", 32'(bus2.pend),    32'd0);
    check("t3_dis.clk_out",    32'(bus2.clk_out), 32'd0);
    bus.wr_en = 1'b0;
    push_w("t3_after", 63, 40, 23, 5, -1, 0, 4'b0000, 1'b0);
    run(1);

    // 4: ch1 -> 6, ch0 -> 4 applied at their own wraps, then sync
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd1;
    bus.wr_div = 16'd6;
    push_w("t4_wr1", 64, 40, 24, 5, -1, 0, 4'b0010, 1'b0);
    run(1);
    bus.wr_ch  = 2'd0;
    bus.wr_div = 16'd4;
    push_w("t4_wr0", 65, 40, 0, 6, -1, 0, 4'b0001, 1'b0);
    run(1);
    bus.wr_en = 1'b0;
    for (int j = 66; j < 80; j++) push_w("t4_pend0", j, 40, j - 65, 6, -1, 0, 4'b0001, 1'b0);
    run(14);
    for (int j = 80; j < 86; j++) push_w("t4_skew", j - 80, 4, j - 65, 6, -1, 0, 4'b0000, 1'b0);
    run(6);
    bus.sync = 1'b1;
    push_w("t4_sync", 0, 4, 0, 6, -1, 0, 4'b0000, 1'b0);
    run(1);
    bus.sync = 1'b0;
    for (int j = 87; j < 110; j++) push_w("t4_aligned", j - 86, 4, j - 86, 6, -1, 0, 4'b0000, 1'b0);
    run(23);

    // 5: enable ch2, write it on the exact wrap edge
    bus.en = 4'b0111;
    for (int j = 110; j < 150; j++) push_w("t5_ch2", j - 86, 4, j - 86, 6, j - 110, 40, 4'b0000, 1'b0);
    run(40);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 2'd2;
    bus.wr_div = 16'd3;
    push_w("t5_wrap_wr", 64, 4, 64, 6, 40, 40, 4'b0100, 1'b0);
    run(1);
    bus.wr_en = 1'b0;
    for (int j = 151; j < 190; j++) push_w("t5_old", j - 86, 4, j - 86, 6, j - 110, 40, 4'b0100, 1'b0);
    run(39);
    for (int j = 190; j < 200; j++) push_w("t5_new", j - 86, 4, j - 86, 6, j - 190, 3, 4'b0000, 1'b0);
    run(10);

    // 6: async reset mid-high-phase, then restart with default divisor
    #2;
    rst = 1'b1;
    #1;
    push_w("t6_async", -1, 0, -1, 0, -1, 0, 4'b0000, 1'b0);
    pop_cmp();
    push_w("t6_held", -1, 0, -1, 0, -1, 0, 4'b0000, 1'b0);
    run(1);
    rst    = 1'b0;
    bus.en = 4'b0001;
    for (int c = 0; c < 41; c++) push_w("t6_restart", c, 40, -1, 0, -1, 0, 4'b0000, 1'b0);
    run(41);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
